// File: rtl/cover_toggle_tracker.sv
// Toggle/level coverage collector: records first hits per slot in a bitmap and
// streams newly covered points as global indices over a valid/ready interface.
module cover_toggle_tracker #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      MODE        = 1,
    parameter int unsigned      DEDUP       = 1,
    parameter longint unsigned  COVER_INDEX = 0,
    parameter longint unsigned  COVER_TOTAL = 11747,
    localparam int unsigned     NSLOT       = (MODE != 0) ? 2 * WIDTH : WIDTH,
    localparam int unsigned     CW          = $clog2(NSLOT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [WIDTH-1:0]  valid,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [63:0]       rpt_index,
    output logic              rpt_rise,
    output logic [CW-1:0]     hit_count,
    output logic [15:0]       drop_count
);

    localparam int unsigned SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
        $error("cover_toggle_tracker: WIDTH must be in 1..256");
    end
    if (COVER_INDEX + 64'(NSLOT) > COVER_TOTAL) begin : g_bad_index
        $error("cover_toggle_tracker: cover indices exceed COVER_TOTAL");
    end

    logic [WIDTH-1:0] prev;
    logic             prev_ok;
    logic [NSLOT-1:0] hit;
    logic [NSLOT-1:0] pending;

    logic             sample_ok;
    logic [NSLOT-1:0] ev;
    logic [NSLOT-1:0] newhit;
    logic [NSLOT-1:0] pend_set;
    logic [NSLOT-1:0] merge;
    logic [NSLOT-1:0] issue_vec;
    logic [SW-1:0]    sel;
    logic             found;
    logic             can_issue;
    logic             do_issue;
    logic [31:0]      drop_sum;
    logic [15:0]      drop_next;

    function automatic logic [CW-1:0] popcnt(input logic [NSLOT-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(NSLOT); i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    // No edges on the first enabled sample, and events are discarded under clear
    assign sample_ok = enable & prev_ok & ~clear;

    if (MODE != 0) begin : g_toggle
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            assign ev[2*i]   = sample_ok &  valid[i] & ~prev[i];
            assign ev[2*i+1] = sample_ok & ~valid[i] &  prev[i];
        end
    end else begin : g_level
        assign ev = {NSLOT{sample_ok}} & valid;
    end

    // Lowest-numbered pending slot, taken from the pre-edge pending set
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int s = int'(NSLOT) - 1; s >= 0; s--) begin
            if (pending[s]) begin
                found = 1'b1;
                sel   = SW'(s);
            end
        end
    end

    assign can_issue = ~rpt_valid | rpt_ready;
    assign do_issue  = can_issue & found & ~clear;

    always_comb begin
        issue_vec = '0;
        if (do_issue) begin
            issue_vec[sel] = 1'b1;
        end
    end

    // A new event re-sets pending after a same-edge issue, so the event wins
    always_comb begin
        newhit   = ev & ~hit;
        pend_set = newhit;
        merge    = '0;
        if (DEDUP == 0) begin
            pend_set = ev;
            merge    = ev & pending & ~issue_vec;
        end
    end

    assign drop_sum  = 32'(drop_count) + 32'(popcnt(merge));
    assign drop_next = (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev    <= '0;
            prev_ok <= 1'b0;
        end else if (enable) begin
            prev    <= valid;
            prev_ok <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit        <= '0;
            pending    <= '0;
            hit_count  <= '0;
            drop_count <= '0;
        end else if (clear) begin
            hit        <= '0;
            pending    <= '0;
            hit_count  <= '0;
            drop_count <= '0;
        end else begin
            hit        <= hit | newhit;
            pending    <= (pending & ~issue_vec) | pend_set;
            hit_count  <= hit_count + popcnt(newhit);
            drop_count <= drop_next;
        end
    end

    // Report register: holds while stalled, reloads or empties on a free slot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_valid <= 1'b0;
            rpt_index <= '0;
            rpt_rise  <= 1'b0;
        end else if (can_issue) begin
            if (do_issue) begin
                rpt_valid <= 1'b1;
                rpt_index <= COVER_INDEX + 64'(sel);
                rpt_rise  <= (MODE != 0) ? ~sel[0] : 1'b1;
            end else begin
                rpt_valid <= 1'b0;
            end
        end
    end

endmodule
